// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_pkg
//  Description : Shared types and constants for the data-memory arbiter:
//                FSM state encoding, response owner tags, burst counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    // Owner of the last granted cycle; IDLE means no grant happened.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        LDR  = 2'd2
    } arb_state_e;

    // Tag that steers a read response back to the port that issued it.
    typedef logic owner_t;

    localparam owner_t c_OWNER_CPU = 1'b0;
    localparam owner_t c_OWNER_LDR = 1'b1;

    // Wide enough for the largest legal loader burst (15).
    localparam int c_BURST_W = 4;

endpackage
`default_nettype wire

// File: rtl/dmem_resp_router.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_resp_router
//  Description : Remembers who issued the read granted last cycle and routes
//                the memory read data back to that port for a single cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_resp_router
    import dmem_arbiter_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rd_grant,
    input  owner_t        rd_owner,
    input  logic [DW-1:0] mem_rd,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          ldr_rvalid,
    output logic [DW-1:0] ldr_rdata
);

    logic   r_pend_q;
    logic   w_pend_d;
    owner_t r_owner_q;
    owner_t w_owner_d;

    // Capture the owner tag of any read accepted this cycle.
    always_comb begin
        w_pend_d  = rd_grant;
        w_owner_d = rd_owner;
    end

    // Tag register; reset drops any read that was in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pend_q  <= 1'b0;
            r_owner_q <= c_OWNER_CPU;
        end else begin
            r_pend_q  <= w_pend_d;
            r_owner_q <= w_owner_d;
        end
    end

    // Demultiplex the returned word using the registered tag, not live grants.
    always_comb begin
        cpu_rvalid = reset && r_pend_q && (r_owner_q == c_OWNER_CPU);
        ldr_rvalid = reset && r_pend_q && (r_owner_q == c_OWNER_LDR);
        cpu_rdata  = cpu_rvalid ? mem_rd : '0;
        ldr_rdata  = ldr_rvalid ? mem_rd : '0;
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port arbiter in front of a single-port data memory.
//                The loader wins contention except after a loader burst of
//                BURST_MAX grants, when the stalled CPU gets one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    // CPU MEM-stage port
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    // Loader / debug port
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic          ldr_rvalid,
    output logic [DW-1:0] ldr_rdata,
    // Single-port memory
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rd
);

    localparam logic [c_BURST_W-1:0] c_BURST_LIMIT = c_BURST_W'(BURST_MAX);

    arb_state_e           r_state_q;
    arb_state_e           w_state_d;
    logic [c_BURST_W-1:0] r_burst_q;
    logic [c_BURST_W-1:0] w_burst_d;
    logic                 w_rd_grant;
    owner_t               w_rd_owner;

    // Grant decision and next-state: single requester wins outright,
    // contention goes to the loader until its burst quota is used up.
    always_comb begin
        cpu_gnt   = 1'b0;
        ldr_gnt   = 1'b0;
        w_state_d = IDLE;
        w_burst_d = '0;
        if (reset) begin
            if (cpu_req && ldr_req) begin
                if ((r_state_q == LDR) && (r_burst_q >= c_BURST_LIMIT)) begin
                    cpu_gnt = 1'b1;
                end else begin
                    ldr_gnt = 1'b1;
                end
            end else begin
                cpu_gnt = cpu_req;
                ldr_gnt = ldr_req;
            end
        end
        if (cpu_gnt) begin
            w_state_d = CPU;
        end else if (ldr_gnt) begin
            w_state_d = LDR;
        end
        // Count only loader grants that actually held off a waiting CPU.
        if (ldr_gnt && cpu_req) begin
            w_burst_d = r_burst_q + c_BURST_W'(1);
        end
    end

    // State and burst counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state_q <= IDLE;
            r_burst_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_burst_q <= w_burst_d;
        end
    end

    // Steer the winner onto the memory port; everything idles at zero.
    always_comb begin
        mem_a      = '0;
        mem_wd     = '0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        w_rd_owner = c_OWNER_CPU;
        if (cpu_gnt) begin
            mem_a  = cpu_addr;
            mem_wd = cpu_wdata;
            mem_we = cpu_we;
            mem_re = !cpu_we;
        end else if (ldr_gnt) begin
            mem_a      = ldr_addr;
            mem_wd     = ldr_wdata;
            mem_we     = ldr_we;
            mem_re     = !ldr_we;
            w_rd_owner = c_OWNER_LDR;
        end
        w_rd_grant = mem_re;
        cpu_stall  = cpu_req && !cpu_gnt;
    end

    dmem_resp_router #(
        .DW (DW)
    ) u_resp_router (
        .clk        (clk),
        .reset      (reset),
        .rd_grant   (w_rd_grant),
        .rd_owner   (w_rd_owner),
        .mem_rd     (mem_rd),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ldr_rvalid (ldr_rvalid),
        .ldr_rdata  (ldr_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter: directed scenarios and
//                random traffic compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int c_BURST = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        ldr_req = 1'b0, ldr_we = 1'b0;
    logic [31:0] ldr_addr = '0, ldr_wdata = '0;
    logic [31:0] mem_rd = '0;
    logic        cpu_gnt, cpu_stall, cpu_rvalid, ldr_gnt, ldr_rvalid;
    logic [31:0] cpu_rdata, ldr_rdata, mem_a, mem_wd;
    logic        mem_we, mem_re;

    dmem_arbiter #(
        .AW        (32),
        .DW        (32),
        .BURST_MAX (c_BURST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ldr_req    (ldr_req),
        .ldr_we     (ldr_we),
        .ldr_addr   (ldr_addr),
        .ldr_wdata  (ldr_wdata),
        .ldr_gnt    (ldr_gnt),
        .ldr_rvalid (ldr_rvalid),
        .ldr_rdata  (ldr_rdata),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Memory seen by the DUT and the bench's own expectation of its contents.
    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];

    // Behavioural model: who owned the last cycle, how many loader grants
    // in a row kept a requesting CPU waiting, and the read now in flight.
    byte         m_last     = "N";
    int          m_run      = 0;
    bit          m_pend     = 1'b0;
    bit          m_pend_ldr = 1'b0;
    logic [31:0] m_pend_data = '0;

    // Per-cycle observations kept for the directed scenario checks.
    logic [15:0] h_cg = '0, h_lg = '0, h_st = '0;
    logic        o_crv, o_lrv;
    logic [31:0] o_crd, o_lrd;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply requests, check every output at the falling
    // edge, then advance model and memory at the rising edge.
    task automatic cycle(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                         input bit lr, input bit lw, input logic [31:0] la, input logic [31:0] ld);
        bit          ecg, elg, ewe, ere, ecv, elv;
        logic [31:0] ea, ed;
        logic        obs_we, obs_re;
        logic [31:0] obs_a, obs_wd;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        ldr_req = lr; ldr_we = lw; ldr_addr = la; ldr_wdata = ld;
        ecg = 1'b0; elg = 1'b0;
        if (reset) begin
            if (cr && lr) begin
                if (m_last == "L" && m_run >= c_BURST) ecg = 1'b1;
                else                                   elg = 1'b1;
            end else begin
                ecg = cr;
                elg = lr;
            end
        end
        ewe = ecg ? cw : (elg ? lw : 1'b0);
        ere = ecg ? !cw : (elg ? !lw : 1'b0);
        ea  = ecg ? ca : (elg ? la : 32'h0);
        ed  = ecg ? cd : (elg ? ld : 32'h0);
        ecv = reset && m_pend && !m_pend_ldr;
        elv = reset && m_pend && m_pend_ldr;
        @(negedge clk);
        chk1("cpu_gnt", cpu_gnt, ecg);
        chk1("ldr_gnt", ldr_gnt, elg);
        chk1("cpu_stall", cpu_stall, cr && !ecg);
        chk1("mem_we", mem_we, ewe);
        chk1("mem_re", mem_re, ere);
        chk32("mem_a", mem_a, ea);
        chk32("mem_wd", mem_wd, ed);
        chk1("cpu_rvalid", cpu_rvalid, ecv);
        chk1("ldr_rvalid", ldr_rvalid, elv);
        chk32("cpu_rdata", cpu_rdata, ecv ? m_pend_data : 32'h0);
        chk32("ldr_rdata", ldr_rdata, elv ? m_pend_data : 32'h0);
        h_cg  = {h_cg[14:0], cpu_gnt};
        h_lg  = {h_lg[14:0], ldr_gnt};
        h_st  = {h_st[14:0], cpu_stall};
        o_crv = cpu_rvalid; o_crd = cpu_rdata;
        o_lrv = ldr_rvalid; o_lrd = ldr_rdata;
        obs_we = mem_we; obs_re = mem_re; obs_a = mem_a; obs_wd = mem_wd;
        @(posedge clk);
        #1;
        if (!reset) begin
            m_last = "N";
            m_run  = 0;
            m_pend = 1'b0;
        end else begin
            m_pend      = ere;
            m_pend_ldr  = elg;
            m_pend_data = ref_mem[ea[7:0]];
            if (ewe) ref_mem[ea[7:0]] = ed;
            m_run  = (elg && cr) ? m_run + 1 : 0;
            m_last = ecg ? "C" : (elg ? "L" : "N");
        end
        if (obs_we === 1'b1) mem[obs_a[7:0]] = obs_wd;
        mem_rd = (obs_re === 1'b1) ? mem[obs_a[7:0]] : $urandom;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
        mem[8'h04] = 32'h44444444; ref_mem[8'h04] = 32'h44444444;
        mem[8'h08] = 32'h88888888; ref_mem[8'h08] = 32'h88888888;
        #1;

        // Reset held with both ports requesting: everything must stay quiet.
        reset = 1'b0;
        cycle(1, 0, 32'h10, 32'h1, 1, 1, 32'h20, 32'h2);
        idle();
        reset = 1'b1;
        idle();

        // Single CPU read returns the preloaded word on the CPU port only.
        cycle(1, 0, 32'h10, 0, 0, 0, 0, 0);
        chk1("r032_gnt", h_cg[0], 1'b1);
        idle();
        chk1("r032_rvalid", o_crv, 1'b1);
        chk32("r032_rdata", o_crd, 32'hDEADBEEF);
        chk1("r032_ldr_rvalid", o_lrv, 1'b0);

        // Continuous contention from IDLE: L,L,L,L,C,L,L,L,L,C.
        idle();
        for (int i = 0; i < 10; i++) cycle(1, 0, 32'h0C, 0, 1, 0, 32'h1C, 0);
        chk32("r033_cpu_seq", {22'h0, h_cg[9:0]}, {22'h0, 10'b0000100001});
        chk32("r033_ldr_seq", {22'h0, h_lg[9:0]}, {22'h0, 10'b1111011110});
        chk32("r033_stall_seq", {22'h0, h_st[9:0]}, {22'h0, 10'b1111011110});
        idle();
        idle();

        // Loader write followed by CPU read of the same word.
        cycle(0, 0, 0, 0, 1, 1, 32'h20, 32'h55);
        cycle(1, 0, 32'h20, 0, 0, 0, 0, 0);
        idle();
        chk1("r034_rvalid", o_crv, 1'b1);
        chk32("r034_rdata", o_crd, 32'h55);

        // Alternating owners back to back: responses must not swap.
        cycle(1, 0, 32'h4, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 32'h8, 0);
        chk32("r035_cpu_rdata", o_crd, 32'h44444444);
        cycle(1, 0, 32'h4, 0, 0, 0, 0, 0);
        chk32("r035_ldr_rdata", o_lrd, 32'h88888888);
        idle();
        chk32("r035_cpu_rdata2", o_crd, 32'h44444444);
        chk1("r035_ldr_quiet", o_lrv, 1'b0);

        // Reset right after a granted CPU read kills the response; first
        // contended cycle afterwards goes to the loader.
        cycle(1, 0, 32'h10, 0, 0, 0, 0, 0);
        reset = 1'b0;
        cycle(1, 0, 32'h10, 0, 1, 0, 32'h8, 0);
        chk1("r036_no_rvalid", o_crv, 1'b0);
        reset = 1'b1;
        cycle(1, 0, 32'h10, 0, 1, 0, 32'h8, 0);
        chk1("r029_ldr_first", h_lg[0], 1'b1);
        chk1("r036_stale_rvalid", o_crv, 1'b0);
        idle();
        idle();

        // CPU drops mid-burst: loader count restarts, four more loader grants.
        cycle(1, 0, 32'h0C, 0, 1, 0, 32'h1C, 0);
        cycle(1, 0, 32'h0C, 0, 1, 0, 32'h1C, 0);
        cycle(0, 0, 0, 0, 1, 0, 32'h1C, 0);
        for (int i = 0; i < 5; i++) cycle(1, 0, 32'h0C, 0, 1, 0, 32'h1C, 0);
        chk32("r037_cpu_seq", {24'h0, h_cg[7:0]}, {24'h0, 8'b00000001});
        chk32("r037_ldr_seq", {24'h0, h_lg[7:0]}, {24'h0, 8'b11111110});
        idle();

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) != 0);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  32'($urandom_range(0, 63)) << 2, $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  32'($urandom_range(0, 63)) << 2, $urandom);
        end
        reset = 1'b1;
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
